decode_stage_pipe: RTL and testbench

//  Pipelined instruction-decode stage: decodes a 32-bit MIPS-style instruction, reads a

---
 rtl/decode_stage_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// Instruction-decode stage for a MIPS-style pipeline. Register file with write-through,
// immediate extension, load-use stall detection and a valid/ready ID/EX output register.
module decode_stage_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_alu_a,
  output logic [XLEN-1:0]   out_alu_b,
  output logic [XLEN-1:0]   out_store_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_memtoreg,
  output logic              out_branch,
  output logic              out_illegal
);

  localparam int unsigned NREGS = 2 ** REG_AW;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;

  logic [XLEN-1:0]   r_regs [NREGS];

  logic              r_valid;
  logic [XLEN-1:0]   r_alu_a;
  logic [XLEN-1:0]   r_alu_b;
  logic [XLEN-1:0]   r_store_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_dest;
  logic              r_regwrite;
  logic              r_memread;
  logic              r_memwrite;
  logic              r_memtoreg;
  logic              r_branch;
  logic              r_illegal;

  logic [5:0]        w_op;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [15:0]       w_imm16;
  logic              w_unused;

  logic              w_wb_writable;
  logic [XLEN-1:0]   w_rs_val;
  logic [XLEN-1:0]   w_rt_val;

  logic              w_regdst;
  logic              w_alusrc;
  logic              w_regwrite;
  logic              w_memread;
  logic              w_memwrite;
  logic              w_memtoreg;
  logic              w_branch;
  logic              w_illegal;
  logic              w_zext;
  logic [XLEN-1:0]   w_imm_ext;
  logic [XLEN-1:0]   w_alu_b;
  logic [REG_AW-1:0] w_dest;

  logic              w_rt_is_src;
  logic              w_dest_nz;
  logic              w_hz;
  logic              w_load;

  assign w_op     = instr[31:26];
  assign w_rs     = instr[21 +: REG_AW];
  assign w_rt     = instr[16 +: REG_AW];
  assign w_rd     = instr[11 +: REG_AW];
  assign w_imm16  = instr[15:0];
  // Upper index bits are intentionally ignored when REG_AW < 5.
  assign w_unused = ^instr;

  assign w_wb_writable = wb_en & ~((ZERO_REG != 0) && (wb_addr == '0));

  // Register file: clocked write, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_writable) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Asynchronous read with same-cycle write-through of the writeback port.
  always_comb begin
    w_rs_val = r_regs[w_rs];
    w_rt_val = r_regs[w_rt];
    if (w_wb_writable && (wb_addr == w_rs)) w_rs_val = wb_data;
    if (w_wb_writable && (wb_addr == w_rt)) w_rt_val = wb_data;
    if ((ZERO_REG != 0) && (w_rs == '0)) w_rs_val = '0;
    if ((ZERO_REG != 0) && (w_rt == '0)) w_rt_val = '0;
  end

  // Main control decode.
  always_comb begin
    w_regdst   = 1'b0;
    w_alusrc   = 1'b0;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    w_zext     = 1'b0;
    case (w_op)
      OP_R: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      OP_LW: begin
        w_alusrc   = 1'b1;
        w_memread  = 1'b1;
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      OP_SW: begin
        w_alusrc   = 1'b1;
        w_memwrite = 1'b1;
      end
      OP_BEQ: begin
        w_branch   = 1'b1;
      end
      OP_ADDI: begin
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
      end
      OP_ORI: begin
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
        w_zext     = 1'b1;
      end
      default: begin
        w_illegal  = 1'b1;
      end
    endcase
  end

  assign w_imm_ext = w_zext ? XLEN'(w_imm16) : XLEN'($signed(w_imm16));
  assign w_alu_b   = w_alusrc ? w_imm_ext : w_rt_val;
  assign w_dest    = w_regdst ? w_rd : w_rt;

  // Load-use hazard: the held lw targets a register this instruction reads.
  assign w_rt_is_src = ~((w_op == OP_LW) | (w_op == OP_ADDI) | (w_op == OP_ORI));
  assign w_dest_nz   = (ZERO_REG == 0) || (r_dest != '0);
  assign w_hz        = r_valid & r_memread & w_dest_nz &
                       ((r_dest == w_rs) | ((r_dest == w_rt) & w_rt_is_src));

  assign in_ready = ~w_hz & (~r_valid | out_ready) & ~flush;
  assign w_load   = in_valid & in_ready;

  // ID/EX output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_store_data <= '0;
      r_imm        <= '0;
      r_dest       <= '0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_branch     <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (flush) begin
      r_valid      <= 1'b0;
    end else if (w_load) begin
      r_valid      <= 1'b1;
      r_alu_a      <= w_rs_val;
      r_alu_b      <= w_alu_b;
      r_store_data <= w_rt_val;
      r_imm        <= w_imm_ext;
      r_dest       <= w_dest;
      r_regwrite   <= w_regwrite;
      r_memread    <= w_memread;
      r_memwrite   <= w_memwrite;
      r_memtoreg   <= w_memtoreg;
      r_branch     <= w_branch;
      r_illegal    <= w_illegal;
    end else if (out_ready && r_valid) begin
      r_valid      <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign out_alu_a      = r_alu_a;
  assign out_alu_b      = r_alu_b;
  assign out_store_data = r_store_data;
  assign out_imm        = r_imm;
  assign out_dest       = r_dest;
  assign out_regwrite   = r_regwrite;
  assign out_memread    = r_memread;
  assign out_memwrite   = r_memwrite;
  assign out_memtoreg   = r_memtoreg;
  assign out_branch     = r_branch;
  assign out_illegal    = r_illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: vector table streamed through a scoreboard plus
// hand-written stall, flush, reset and narrow-configuration sequences.
module tb_decode_stage_pipe;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [5:0]  ctrl;
  } exp_t;

  typedef struct packed {
    logic [31:0] ins;
    exp_t        e;
  } vec_t;

  localparam logic [5:0] C_R  = 6'b100000;
  localparam logic [5:0] C_LW = 6'b110100;
  localparam logic [5:0] C_SW = 6'b001000;
  localparam logic [5:0] C_BR = 6'b000010;
  localparam logic [5:0] C_IL = 6'b000001;
  localparam int NVEC = 9;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, wb_en, out_valid, out_ready;
  logic [31:0] instr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, out_alu_a, out_alu_b, out_store_data, out_imm;
  logic [4:0]  out_dest;
  logic        out_regwrite, out_memread, out_memwrite, out_memtoreg, out_branch, out_illegal;

  logic        s_flush, s_in_valid, s_in_ready, s_wb_en, s_out_valid, s_out_ready;
  logic [31:0] s_instr;
  logic [2:0]  s_wb_addr, s_out_dest;
  logic [15:0] s_wb_data, s_out_alu_a, s_out_alu_b, s_out_store_data, s_out_imm;
  logic        s_out_regwrite, s_out_memread, s_out_memwrite, s_out_memtoreg, s_out_branch, s_out_illegal;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs [NVEC];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  decode_stage_pipe #(.XLEN(32), .REG_AW(5), .ZERO_REG(1)) u_dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
    .out_store_data(out_store_data), .out_imm(out_imm), .out_dest(out_dest),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_memtoreg(out_memtoreg), .out_branch(out_branch), .out_illegal(out_illegal)
  );

  decode_stage_pipe #(.XLEN(16), .REG_AW(3), .ZERO_REG(1)) u_dut16 (
    .clock(clock), .reset(reset), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .instr(s_instr), .wb_en(s_wb_en), .wb_addr(s_wb_addr), .wb_data(s_wb_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_alu_a(s_out_alu_a),
    .out_alu_b(s_out_alu_b), .out_store_data(s_out_store_data), .out_imm(s_out_imm),
    .out_dest(s_out_dest), .out_regwrite(s_out_regwrite), .out_memread(s_out_memread),
    .out_memwrite(s_out_memwrite), .out_memtoreg(s_out_memtoreg), .out_branch(s_out_branch),
    .out_illegal(s_out_illegal)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                              input logic [31:0] imm, input logic [4:0] dest,
                              input logic [5:0] ctrl);
    exp_t e;
    e.a = a; e.b = b; e.sd = sd; e.imm = imm; e.dest = dest; e.ctrl = ctrl;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    tick();
    wb_en = 1'b0;
  endtask

  // Offer an instruction, wait (bounded) for acceptance, record its expected output.
  task automatic send(input logic [31:0] ins, input exp_t e);
    int n = 0;
    in_valid = 1'b1; instr = ins;
    #1;
    while (!in_ready && n < 20) begin
      tick(); #1; n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept instr=%0h", ins);
    end else begin
      sb.push_back(e);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: compare every output at the cycle it is consumed.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_unexpected actual=valid_output required=none");
      end else begin
        mon_e = sb.pop_front();
        chk("sb_alu_a", 64'(out_alu_a), 64'(mon_e.a));
        chk("sb_alu_b", 64'(out_alu_b), 64'(mon_e.b));
        chk("sb_store_data", 64'(out_store_data), 64'(mon_e.sd));
        chk("sb_imm", 64'(out_imm), 64'(mon_e.imm));
        chk("sb_dest", 64'(out_dest), 64'(mon_e.dest));
        chk("sb_ctrl", 64'({out_regwrite, out_memread, out_memwrite, out_memtoreg,
                            out_branch, out_illegal}), 64'(mon_e.ctrl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vecs[0] = '{rtype(5'd1, 5'd2, 5'd5), mk(32'h100, 32'h200, 32'h200, 32'h2820, 5'd5, C_R)};
    vecs[1] = '{itype(6'h23, 5'd3, 5'd6, 16'h0008), mk(32'h300, 32'h8, 32'h0, 32'h8, 5'd6, C_LW)};
    vecs[2] = '{itype(6'h2B, 5'd1, 5'd4, 16'hFFFC),
                mk(32'h100, 32'hFFFFFFFC, 32'hFFFF0000, 32'hFFFFFFFC, 5'd4, C_SW)};
    vecs[3] = '{itype(6'h04, 5'd1, 5'd2, 16'h8001),
                mk(32'h100, 32'h200, 32'h200, 32'hFFFF8001, 5'd2, C_BR)};
    vecs[4] = '{itype(6'h08, 5'd4, 5'd7, 16'h7FFF),
                mk(32'hFFFF0000, 32'h7FFF, 32'h0, 32'h7FFF, 5'd7, C_R)};
    vecs[5] = '{itype(6'h0D, 5'd4, 5'd8, 16'h8000),
                mk(32'hFFFF0000, 32'h8000, 32'h0, 32'h8000, 5'd8, C_R)};
    vecs[6] = '{itype(6'h3F, 5'd1, 5'd2, 16'h1234),
                mk(32'h100, 32'h200, 32'h200, 32'h1234, 5'd2, C_IL)};
    vecs[7] = '{itype(6'h23, 5'd1, 5'd9, 16'h0000), mk(32'h100, 32'h0, 32'h0, 32'h0, 5'd9, C_LW)};
    vecs[8] = '{itype(6'h08, 5'd2, 5'd9, 16'h0001), mk(32'h200, 32'h1, 32'h0, 32'h1, 5'd9, C_R)};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; wb_en = 1'b0;
    wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    s_flush = 1'b0; s_in_valid = 1'b0; s_instr = '0; s_wb_en = 1'b0;
    s_wb_addr = '0; s_wb_data = '0; s_out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu_a", 64'(out_alu_a), 64'd0);
    chk("rst_ctrl", 64'({out_regwrite, out_memread, out_memwrite, out_memtoreg,
                         out_branch, out_illegal}), 64'd0);

    // T1: r5 reads 0 after reset, then reads the written value.
    send(itype(6'h08, 5'd5, 5'd6, 16'hFFFF),
         mk(32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 5'd6, C_R));
    wb(5'd5, 32'h1234);
    send(itype(6'h08, 5'd5, 5'd6, 16'hFFFF),
         mk(32'h1234, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 5'd6, C_R));
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_alu_a", 64'(out_alu_a), 64'h1234);
    chk("t1_alu_b", 64'(out_alu_b), 64'hFFFFFFFF);
    chk("t1_dest", 64'(out_dest), 64'd6);
    chk("t1_regwrite", 64'(out_regwrite), 64'd1);

    wb(5'd1, 32'h100); wb(5'd2, 32'h200); wb(5'd3, 32'h300); wb(5'd4, 32'hFFFF0000);

    // Table stream at full throughput.
    c0 = cyc;
    for (int i = 0; i < NVEC; i++) send(vecs[i].ins, vecs[i].e);
    chk("throughput_cycles", 64'(cyc - c0), 64'(NVEC));

    // T2: writeback and read of r3 in the accepting cycle.
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hAB;
    send(rtype(5'd3, 5'd3, 5'd4), mk(32'hAB, 32'hAB, 32'hAB, 32'h2020, 5'd4, C_R));
    wb_en = 1'b0;
    chk("t2_alu_a", 64'(out_alu_a), 64'hAB);
    chk("t2_alu_b", 64'(out_alu_b), 64'hAB);

    // T3: load-use stall, one bubble, dependent add picks up a bypassed writeback.
    send(itype(6'h23, 5'd1, 5'd2, 16'h0000), mk(32'h100, 32'h0, 32'h200, 32'h0, 5'd2, C_LW));
    in_valid = 1'b1; instr = rtype(5'd2, 5'd2, 5'd3);
    #1;
    chk("t3_stall_in_ready", 64'(in_ready), 64'd0);
    chk("t3_lw_valid", 64'(out_valid), 64'd1);
    tick();
    chk("t3_bubble", 64'(out_valid), 64'd0);
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h555;
    #1;
    chk("t3_resume_in_ready", 64'(in_ready), 64'd1);
    if (in_ready) sb.push_back(mk(32'h555, 32'h555, 32'h555, 32'h1820, 5'd3, C_R));
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("t3_add_valid", 64'(out_valid), 64'd1);

    // T4: backpressure holds outputs, release loads the next instruction on that edge.
    send(rtype(5'd1, 5'd1, 5'd5), mk(32'h100, 32'h100, 32'h100, 32'h2820, 5'd5, C_R));
    out_ready = 1'b0;
    in_valid = 1'b1; instr = itype(6'h0D, 5'd0, 5'd7, 16'h0005);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_in_ready_low", 64'(in_ready), 64'd0);
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_a", 64'(out_alu_a), 64'h100);
      chk("t4_hold_imm", 64'(out_imm), 64'h2820);
      chk("t4_hold_dest", 64'(out_dest), 64'd5);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_release_in_ready", 64'(in_ready), 64'd1);
    if (in_ready) sb.push_back(mk(32'h0, 32'h5, 32'h0, 32'h5, 5'd7, C_R));
    tick();
    in_valid = 1'b0;
    chk("t4_next_b", 64'(out_alu_b), 64'h5);

    // T5: zero-extended ori, illegal opcode, writes to r0 ignored.
    send(itype(6'h0D, 5'd0, 5'd1, 16'h8000), mk(32'h0, 32'h8000, 32'h100, 32'h8000, 5'd1, C_R));
    chk("t5_ori_imm", 64'(out_imm), 64'h8000);
    send(itype(6'h3F, 5'd0, 5'd0, 16'h0000), mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, C_IL));
    chk("t5_illegal", 64'(out_illegal), 64'd1);
    chk("t5_illegal_ctrl", 64'({out_regwrite, out_memread, out_memwrite, out_memtoreg,
                                out_branch}), 64'd0);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    send(rtype(5'd0, 5'd0, 5'd9), mk(32'h0, 32'h0, 32'h0, 32'h4820, 5'd9, C_R));
    wb_en = 1'b0;
    send(rtype(5'd0, 5'd0, 5'd9), mk(32'h0, 32'h0, 32'h0, 32'h4820, 5'd9, C_R));
    chk("t5_r0_zero", 64'(out_alu_a), 64'd0);

    // T6: flush discards the held output and the offered instruction.
    send(rtype(5'd1, 5'd2, 5'd10), mk(32'h100, 32'h555, 32'h555, 32'h5020, 5'd10, C_R));
    out_ready = 1'b0;
    flush = 1'b1; in_valid = 1'b1; instr = itype(6'h08, 5'd1, 5'd11, 16'h0007);
    #1;
    chk("t6_flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t6_flush_bubble", 64'(out_valid), 64'd0);
    if (sb.size() > 0) void'(sb.pop_front());
    out_ready = 1'b1;
    tick();
    chk("t6_dropped", 64'(out_valid), 64'd0);

    // Reset while an output is held: instruction lost, regfile cleared.
    send(rtype(5'd1, 5'd2, 5'd12), mk(32'h100, 32'h555, 32'h555, 32'h6020, 5'd12, C_R));
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    if (sb.size() > 0) void'(sb.pop_front());
    out_ready = 1'b1;
    send(rtype(5'd1, 5'd1, 5'd13), mk(32'h0, 32'h0, 32'h0, 32'h6820, 5'd13, C_R));
    chk("midrst_rf_cleared", 64'(out_alu_a), 64'd0);

    // Narrow configuration: XLEN=16, REG_AW=3, indices from field[2:0].
    s_wb_en = 1'b1; s_wb_addr = 3'd5; s_wb_data = 16'h1234;
    tick();
    s_wb_en = 1'b0;
    s_in_valid = 1'b1; s_instr = itype(6'h08, 5'b11101, 5'b01110, 16'hFFFF);
    #1;
    chk("n16_in_ready", 64'(s_in_ready), 64'd1);
    tick();
    s_in_valid = 1'b0;
    chk("n16_valid", 64'(s_out_valid), 64'd1);
    chk("n16_alu_a", 64'(s_out_alu_a), 64'h1234);
    chk("n16_alu_b", 64'(s_out_alu_b), 64'hFFFF);
    chk("n16_dest", 64'(s_out_dest), 64'd6);
    chk("n16_regwrite", 64'(s_out_regwrite), 64'd1);

    tick(); tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
